// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bus scheduler:
//   - state_e       : scheduler FSM states (3-bit encoding)
//   - MaxBytesDefault / CountWidthDefault : default transfer size and byte-count width
//   - RtcAddr       : 7-bit slave address of the clock board RTC
package i2c_pkg;

  localparam int MaxBytesDefault   = 8;
  localparam int CountWidthDefault = $clog2(MaxBytesDefault + 1);

  localparam logic [6:0] RtcAddr = 7'h68;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT     = 3'd1,
    LAUNCH    = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4,
    COMPLETE  = 3'd5
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   req[1:0]    : request levels
//   last_grant  : index served most recently (register lives in the parent)
//   enable      : arbitration is evaluated only while high
//   grant       : granted index
//   grant_valid : a grant was issued this cycle
module rr_arbiter2
  import i2c_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic       grant,
  output logic       grant_valid
);

  // Pick the lone requester, or the one not served last when both request.
  always_comb begin
    grant       = 1'b0;
    grant_valid = 1'b0;
    if (enable) begin
      case (req)
        2'b01: begin
          grant       = 1'b0;
          grant_valid = 1'b1;
        end
        2'b10: begin
          grant       = 1'b1;
          grant_valid = 1'b1;
        end
        2'b11: begin
          grant       = ~last_grant;
          grant_valid = 1'b1;
        end
        default: begin
          grant       = 1'b0;
          grant_valid = 1'b0;
        end
      endcase
    end else begin
      grant       = 1'b0;
      grant_valid = 1'b0;
    end
  end

endmodule

// File: rtl/i2c_bus_scheduler.sv
// Shares one I2C master between two requesters (0: RTC time-set writer,
// 1: periodic RTC/display reader). Arbitrates round-robin, launches one
// transaction per grant, retries clock-stretch timeouts and reports
// completion with per-requester done/error pulses.
// Ports:
//   clock, reset        : system clock, asynchronous active-low reset
//   req/address/tx_*/rx_count : per-requester request and transfer description
//   done/error          : one-cycle completion / failure pulse per requester
//   rx_data             : read bytes of the last transaction (masked to rx_count)
//   busy                : transaction in progress (GRANT..COMPLETE)
//   m_*                 : registered start/address/count/data interface to the master
//   m_rx_data, m_ready, m_timeout : master read data, idle flag, stretch timeout
module i2c_bus_scheduler
  import i2c_pkg::*;
#(
  parameter  int MaxBytes       = MaxBytesDefault,
  parameter  int MaxRetries     = 2,
  parameter  int StartAckCycles = 2000000,
  localparam int CountWidth     = $clog2(MaxBytes + 1)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [1:0]                         req,
  input  logic [1:0][6:0]                    address,
  input  logic [1:0][CountWidth-1:0]         tx_count,
  input  logic [1:0][8*MaxBytes-1:0]         tx_data,
  input  logic [1:0][CountWidth-1:0]         rx_count,
  output logic [1:0]                         done,
  output logic [1:0]                         error,
  output logic [8*MaxBytes-1:0]              rx_data,
  output logic                               busy,
  output logic                               m_start,
  output logic [6:0]                         m_address,
  output logic [CountWidth-1:0]              m_tx_count,
  output logic [8*MaxBytes-1:0]              m_tx_data,
  output logic [CountWidth-1:0]              m_rx_count,
  input  logic [8*MaxBytes-1:0]              m_rx_data,
  input  logic                               m_ready,
  input  logic                               m_timeout
);

  localparam int DataWidth  = 8 * MaxBytes;
  localparam int WaitWidth  = $clog2(StartAckCycles + 1);
  localparam int RetryWidth = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

  localparam logic [CountWidth-1:0] MaxCount = CountWidth'(MaxBytes);
  localparam logic [WaitWidth-1:0]  AckLast  = WaitWidth'(StartAckCycles - 1);
  localparam logic [RetryWidth-1:0] RetryMax = RetryWidth'(MaxRetries);

  state_e                  state_q, state_d;
  logic                    grant_q, grant_d;
  logic                    last_grant_q, last_grant_d;
  logic [RetryWidth-1:0]   retry_q, retry_d;
  logic [WaitWidth-1:0]    wait_q, wait_d;
  logic [1:0]              done_q, done_d;
  logic [1:0]              error_q, error_d;
  logic                    busy_q, busy_d;
  logic                    m_start_q, m_start_d;
  logic [6:0]              m_address_q, m_address_d;
  logic [CountWidth-1:0]   m_tx_count_q, m_tx_count_d;
  logic [DataWidth-1:0]    m_tx_data_q, m_tx_data_d;
  logic [CountWidth-1:0]   m_rx_count_q, m_rx_count_d;
  logic [DataWidth-1:0]    rx_data_q, rx_data_d;

  logic                    arb_grant_s;
  logic                    arb_valid_s;
  logic                    invalid_s;
  logic                    finish_s;
  logic                    fail_s;
  logic                    idx_s;
  logic [DataWidth-1:0]    rx_mask_s;

  rr_arbiter2 u_arb (
    .req         (req),
    .last_grant  (last_grant_q),
    .enable      (state_q == GRANT),
    .grant       (arb_grant_s),
    .grant_valid (arb_valid_s)
  );

  // A request the master cannot carry out is rejected without touching the bus.
  always_comb begin
    invalid_s = (tx_count[arb_grant_s] > MaxCount) ||
                (rx_count[arb_grant_s] > MaxCount) ||
                ((tx_count[arb_grant_s] == '0) && (rx_count[arb_grant_s] == '0));
  end

  // Keep only the first m_rx_count bytes of the master's read buffer.
  always_comb begin
    rx_mask_s = '0;
    for (int b = 0; b < MaxBytes; b++) begin
      rx_mask_s[8*b +: 8] = (CountWidth'(b) < m_rx_count_q) ? 8'hFF : 8'h00;
    end
  end

  // Next-state and output logic of the scheduler FSM.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    retry_d      = retry_q;
    wait_d       = wait_q;
    m_address_d  = m_address_q;
    m_tx_count_d = m_tx_count_q;
    m_tx_data_d  = m_tx_data_q;
    m_rx_count_d = m_rx_count_q;
    rx_data_d    = rx_data_q;
    done_d       = 2'b00;
    error_d      = 2'b00;
    finish_s     = 1'b0;
    fail_s       = 1'b0;

    case (state_q)
      IDLE: begin
        if ((req != 2'b00) && m_ready) begin
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (arb_valid_s) begin
          grant_d      = arb_grant_s;
          last_grant_d = arb_grant_s;
          m_address_d  = address[arb_grant_s];
          m_tx_count_d = tx_count[arb_grant_s];
          m_tx_data_d  = tx_data[arb_grant_s];
          m_rx_count_d = rx_count[arb_grant_s];
          retry_d      = '0;
          if (invalid_s) begin
            state_d  = COMPLETE;
            finish_s = 1'b1;
            fail_s   = 1'b1;
          end else begin
            state_d = LAUNCH;
          end
        end else begin
          // Request vanished between IDLE and GRANT: nothing to serve.
          state_d = IDLE;
        end
      end
      LAUNCH: begin
        wait_d  = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!m_ready) begin
          state_d = WAIT_DONE;
        end else if (wait_q == AckLast) begin
          state_d  = COMPLETE;
          finish_s = 1'b1;
          fail_s   = 1'b1;
        end else begin
          wait_d = wait_q + WaitWidth'(1);
        end
      end
      WAIT_DONE: begin
        if (m_ready) begin
          if (m_timeout && (retry_q < RetryMax)) begin
            retry_d = retry_q + RetryWidth'(1);
            state_d = LAUNCH;
          end else begin
            state_d  = COMPLETE;
            finish_s = 1'b1;
            fail_s   = m_timeout;
          end
        end else begin
          state_d = WAIT_DONE;
        end
      end
      COMPLETE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Completion is flagged on entry to COMPLETE so done/error/rx_data are
    // visible during the COMPLETE cycle itself.
    idx_s = (state_q == GRANT) ? arb_grant_s : grant_q;
    if (finish_s) begin
      done_d[idx_s]  = 1'b1;
      error_d[idx_s] = fail_s;
      rx_data_d      = (state_q == GRANT) ? '0 : (m_rx_data & rx_mask_s);
    end else begin
      done_d  = 2'b00;
      error_d = 2'b00;
    end

    busy_d    = (state_d != IDLE);
    m_start_d = (state_d == LAUNCH);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      retry_q      <= '0;
      wait_q       <= '0;
      done_q       <= 2'b00;
      error_q      <= 2'b00;
      busy_q       <= 1'b0;
      m_start_q    <= 1'b0;
      m_address_q  <= 7'h00;
      m_tx_count_q <= '0;
      m_tx_data_q  <= '0;
      m_rx_count_q <= '0;
      rx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      retry_q      <= retry_d;
      wait_q       <= wait_d;
      done_q       <= done_d;
      error_q      <= error_d;
      busy_q       <= busy_d;
      m_start_q    <= m_start_d;
      m_address_q  <= m_address_d;
      m_tx_count_q <= m_tx_count_d;
      m_tx_data_q  <= m_tx_data_d;
      m_rx_count_q <= m_rx_count_d;
      rx_data_q    <= rx_data_d;
    end
  end

  assign done       = done_q;
  assign error      = error_q;
  assign busy       = busy_q;
  assign m_start    = m_start_q;
  assign m_address  = m_address_q;
  assign m_tx_count = m_tx_count_q;
  assign m_tx_data  = m_tx_data_q;
  assign m_rx_count = m_rx_count_q;
  assign rx_data    = rx_data_q;

endmodule

// File: tb/tb_i2c_bus_scheduler.sv
// Self-checking bench for i2c_bus_scheduler with a behavioural I2C master.
module tb_i2c_bus_scheduler;
  import i2c_pkg::*;

  localparam int MB = 8;
  localparam int CW = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [1:0]        req = 2'b00;
  logic [1:0][6:0]   address = '0;
  logic [1:0][CW-1:0] tx_count = '0;
  logic [1:0][8*MB-1:0] tx_data = '0;
  logic [1:0][CW-1:0] rx_count = '0;
  logic [1:0]        done, error;
  logic [8*MB-1:0]   rx_data;
  logic              busy, m_start;
  logic [6:0]        m_address;
  logic [CW-1:0]     m_tx_count, m_rx_count;
  logic [8*MB-1:0]   m_tx_data;
  logic [8*MB-1:0]   m_rx_data;
  logic              m_ready, m_timeout;

  i2c_bus_scheduler #(.MaxBytes(MB), .MaxRetries(2), .StartAckCycles(16)) dut (
    .clock(clock), .reset(reset), .req(req), .address(address),
    .tx_count(tx_count), .tx_data(tx_data), .rx_count(rx_count),
    .done(done), .error(error), .rx_data(rx_data), .busy(busy),
    .m_start(m_start), .m_address(m_address), .m_tx_count(m_tx_count),
    .m_tx_data(m_tx_data), .m_rx_count(m_rx_count), .m_rx_data(m_rx_data),
    .m_ready(m_ready), .m_timeout(m_timeout)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // master model controls (written by the stimulus process only)
  int          ack_delay     = 5;
  int          busy_cycles   = 50;
  int          timeouts_left = 0;
  logic        no_ack        = 1'b0;
  logic        hold_ready    = 1'b0;
  logic [63:0] rx_val        = 64'h0;

  // master model records (written by the model only)
  int          start_cnt = 0;
  logic [6:0]  cap_addr[$];
  logic [CW-1:0] cap_txc[$];
  logic [CW-1:0] cap_rxc[$];
  logic [63:0] cap_txd[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int max_cyc, output logic [1:0] d, output logic [1:0] e, output int cyc);
    cyc = 0;
    while (done == 2'b00 && cyc < max_cyc) begin
      @(negedge clock);
      cyc++;
    end
    d = done;
    e = error;
    if (done == 2'b00) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", max_cyc);
    end
  endtask

  task automatic wait_sig_start(input int max_cyc);
    int c = 0;
    while (m_start !== 1'b1 && c < max_cyc) begin
      @(negedge clock);
      c++;
    end
    if (m_start !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL start_timeout: got no m_start expected m_start within %0d cycles", max_cyc);
    end
  endtask

  // Behavioural master: ready drops ack_delay cycles after start, rises after busy_cycles.
  initial begin
    m_ready   = 1'b1;
    m_timeout = 1'b0;
    m_rx_data = '0;
    forever begin
      @(negedge clock);
      if (m_start === 1'b1 && reset === 1'b1) begin
        start_cnt++;
        cap_addr.push_back(m_address);
        cap_txc.push_back(m_tx_count);
        cap_rxc.push_back(m_rx_count);
        cap_txd.push_back(m_tx_data);
        if (!no_ack) begin
          repeat (ack_delay - 1) @(negedge clock);
          m_ready = 1'b0;
          repeat (busy_cycles) @(negedge clock);
          m_rx_data = rx_val;
          m_timeout = (timeouts_left > 0);
          if (timeouts_left > 0) timeouts_left--;
          m_ready = 1'b1;
        end
      end else begin
        m_ready = !hold_ready;
      end
    end
  end

  typedef struct {
    logic [1:0]    req;
    logic [CW-1:0] tx0, rx0, tx1, rx1;
    logic [1:0]    exp_done;
    logic [1:0]    exp_err;
    int            exp_starts;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [1:0] d, e;
    int cyc, s0;

    vecs[0] = '{2'b11, 4'd1, 4'd1, 4'd1, 4'd1, 2'b10, 2'b00, 1}; // last_grant=0 -> 1
    vecs[1] = '{2'b11, 4'd1, 4'd1, 4'd1, 4'd1, 2'b01, 2'b00, 1}; // last_grant=1 -> 0
    vecs[2] = '{2'b01, 4'd9, 4'd1, 4'd0, 4'd0, 2'b01, 2'b01, 0}; // tx_count too big
    vecs[3] = '{2'b10, 4'd0, 4'd0, 4'd2, 4'd9, 2'b10, 2'b10, 0}; // rx_count too big
    vecs[4] = '{2'b01, 4'd0, 4'd0, 4'd0, 4'd0, 2'b01, 2'b01, 0}; // both counts zero
    vecs[5] = '{2'b01, 4'd8, 4'd8, 4'd0, 4'd0, 2'b01, 2'b00, 1}; // max sizes accepted
    vecs[6] = '{2'b10, 4'd0, 4'd0, 4'd0, 4'd1, 2'b10, 2'b00, 1}; // read-only
    vecs[7] = '{2'b11, 4'd9, 4'd0, 4'd1, 4'd1, 2'b01, 2'b01, 0}; // last=1: invalid 0 wins

    // reset state
    #1;
    check("rst_done", {62'd0, done}, 64'd0);
    check("rst_error", {62'd0, error}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_m_start", {63'd0, m_start}, 64'd0);
    check("rst_m_address", {57'd0, m_address}, 64'd0);
    check("rst_rx_data", rx_data, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // single read from the RTC by requester 1
    address[1] = RtcAddr; tx_count[1] = 4'd1; tx_data[1] = '0; rx_count[1] = 4'd3;
    rx_val = 64'hAABB_CCDD_EE23_5930;
    s0 = start_cnt;
    req = 2'b10;
    wait_done(1000, d, e, cyc);
    check("read_done", {62'd0, d}, 64'd2);
    check("read_error", {62'd0, e}, 64'd0);
    check("read_rx_data", rx_data, 64'h0000_0000_0023_5930);
    check("read_starts", start_cnt - s0, 64'd1);
    check("read_m_address", {57'd0, cap_addr[s0]}, {57'd0, RtcAddr});
    req = 2'b00;
    @(negedge clock);
    check("done_one_cycle", {62'd0, done}, 64'd0);
    @(negedge clock);

    // simultaneous requests from last_grant=1: 0 first, then 1, then 0 again
    tx_count = '{4'd1, 4'd1}; rx_count = '{4'd1, 4'd1};
    req = 2'b11;
    wait_done(1000, d, e, cyc);
    check("rr_first", {62'd0, d}, 64'd1);
    req = 2'b10;
    wait_done(1000, d, e, cyc);
    if (d == 2'b01) begin
      @(negedge clock);
      wait_done(1000, d, e, cyc);
    end
    check("rr_second", {62'd0, d}, 64'd2);
    req = 2'b00;
    repeat (2) @(negedge clock);
    req = 2'b11;
    wait_done(1000, d, e, cyc);
    check("rr_third", {62'd0, d}, 64'd1);
    req = 2'b00;
    repeat (2) @(negedge clock);

    // table-driven vectors
    for (int i = 0; i < 8; i++) begin
      tx_count[0] = vecs[i].tx0; rx_count[0] = vecs[i].rx0;
      tx_count[1] = vecs[i].tx1; rx_count[1] = vecs[i].rx1;
      s0 = start_cnt;
      req = vecs[i].req;
      wait_done(1000, d, e, cyc);
      check($sformatf("vec%0d_done", i), {62'd0, d}, {62'd0, vecs[i].exp_done});
      check($sformatf("vec%0d_error", i), {62'd0, e}, {62'd0, vecs[i].exp_err});
      check($sformatf("vec%0d_starts", i), start_cnt - s0, vecs[i].exp_starts);
      req = 2'b00;
      repeat (2) @(negedge clock);
    end

    // invalid count: done arrives in the second busy cycle, no start
    tx_count[0] = 4'd9; rx_count[0] = 4'd0;
    s0 = start_cnt;
    req = 2'b01;
    cyc = 0;
    while (busy !== 1'b1 && cyc < 20) begin @(negedge clock); cyc++; end
    wait_done(20, d, e, cyc);
    check("inv_latency", cyc, 64'd1);
    check("inv_done_err", {60'd0, d, e}, 64'h5);
    check("inv_no_start", start_cnt - s0, 64'd0);
    req = 2'b00;
    repeat (2) @(negedge clock);

    // retries: two timeouts then success, inputs changed after grant
    address[0] = 7'h50; tx_count[0] = 4'd2; tx_data[0] = 64'h0000_0000_0000_1234; rx_count[0] = 4'd0;
    timeouts_left = 2;
    s0 = start_cnt;
    req = 2'b01;
    wait_sig_start(50);
    address[0] = 7'h11; tx_count[0] = 4'd5; tx_data[0] = 64'hFFFF;
    wait_done(1000, d, e, cyc);
    check("retry_ok_done_err", {60'd0, d, e}, 64'h4);
    check("retry_ok_starts", start_cnt - s0, 64'd3);
    for (int k = s0; k < start_cnt; k++) begin
      check($sformatf("retry_addr%0d", k - s0), {57'd0, cap_addr[k]}, 64'h50);
      check($sformatf("retry_txc%0d", k - s0), {60'd0, cap_txc[k]}, 64'd2);
      check($sformatf("retry_txd%0d", k - s0), cap_txd[k], 64'h1234);
    end
    req = 2'b00;
    repeat (2) @(negedge clock);

    // retries exhausted
    address[0] = 7'h50; tx_count[0] = 4'd2;
    timeouts_left = 3;
    s0 = start_cnt;
    req = 2'b01;
    wait_done(1000, d, e, cyc);
    check("retry_fail_done_err", {60'd0, d, e}, 64'h5);
    check("retry_fail_starts", start_cnt - s0, 64'd3);
    req = 2'b00;
    timeouts_left = 0;
    repeat (60) @(negedge clock);

    // no ack: error 16 cycles after WAIT_ACK entry (17 negedges after the start pulse)
    no_ack = 1'b1;
    req = 2'b01;
    wait_sig_start(50);
    wait_done(100, d, e, cyc);
    check("noack_latency", cyc, 64'd17);
    check("noack_done_err", {60'd0, d, e}, 64'h5);
    req = 2'b00;
    repeat (2) @(negedge clock);
    check("noack_busy_clear", {63'd0, busy}, 64'd0);
    no_ack = 1'b0;

    // master not ready: stay in IDLE
    hold_ready = 1'b1;
    repeat (2) @(negedge clock);
    s0 = start_cnt;
    req = 2'b01;
    repeat (5) @(negedge clock);
    check("notready_busy", {63'd0, busy}, 64'd0);
    hold_ready = 1'b0;
    wait_done(1000, d, e, cyc);
    check("notready_done", {62'd0, d}, 64'd1);
    req = 2'b00;
    repeat (2) @(negedge clock);

    // reset during WAIT_DONE, request held through reset
    tx_count[1] = 4'd1; rx_count[1] = 4'd1; address[1] = RtcAddr;
    req = 2'b10;
    cyc = 0;
    while (m_ready !== 1'b0 && cyc < 50) begin @(negedge clock); cyc++; end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_m_start", {63'd0, m_start}, 64'd0);
    check("midrst_m_address", {57'd0, m_address}, 64'd0);
    check("midrst_rx_data", rx_data, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    s0 = start_cnt;
    wait_done(1000, d, e, cyc);
    check("midrst_done_err", {60'd0, d, e}, 64'h8);
    check("midrst_starts", start_cnt - s0, 64'd1);
    req = 2'b00;
    repeat (3) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
